// File: rtl/tnn_pkg.sv
// Shared types and sizing for the TNN neuron input path.
package tnn_pkg;

  localparam int TNN_N_FEAT = 5;
  localparam int TNN_Q_W    = 3;

  typedef logic [TNN_Q_W-1:0] tnn_feat_t;
  typedef tnn_feat_t [TNN_N_FEAT-1:0] tnn_sample_t;

  typedef enum logic {
    COLLECT = 1'b0,
    DISCARD = 1'b1
  } tnn_pack_state_e;

endpackage

// File: rtl/tnn_quant.sv
// Combinational round-half-up quantizer with saturation: IN_W-bit unsigned to Q_W bits.
module tnn_quant
  import tnn_pkg::*;
#(
  parameter int IN_W = 8,
  parameter int Q_W  = TNN_Q_W
) (
  input  logic [IN_W-1:0] x,
  output logic [Q_W-1:0]  q
);

  localparam int            SHIFT = IN_W - Q_W;
  localparam logic [IN_W:0] HALF  = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic [IN_W:0] Q_MAX = (IN_W+1)'((1 << Q_W) - 1);

  // One extra bit so the rounding add cannot wrap near full scale.
  logic [IN_W:0] sum;
  logic [IN_W:0] shifted;

  always_comb begin
    sum     = {1'b0, x} + HALF;
    shifted = sum >> SHIFT;
    if (shifted > Q_MAX) begin
      q = Q_MAX[Q_W-1:0];
    end else begin
      q = shifted[Q_W-1:0];
    end
  end

endmodule

// File: rtl/tnn_feature_packer.sv
// Quantizes a stream of raw features and packs N_FEAT of them per sample into a
// held output word, checking sample framing against s_last.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   COLLECT | writing quantized beats into slot idx of the assembly register
//   DISCARD | over-long sample seen; swallow beats up to and including s_last
module tnn_feature_packer
  import tnn_pkg::*;
#(
  parameter int N_FEAT = TNN_N_FEAT,
  parameter int IN_W   = 8,
  parameter int Q_W    = TNN_Q_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_W-1:0]         s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [N_FEAT*Q_W-1:0]   m_feat,
  output logic                    frame_err
);

  localparam int               IDX_W    = $clog2(N_FEAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  typedef logic [N_FEAT-1:0][Q_W-1:0] sample_t;

  tnn_pack_state_e         state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  sample_t                 asm_q, asm_d;
  logic                    m_valid_q;
  logic [N_FEAT*Q_W-1:0]   m_feat_q;
  logic                    frame_err_q;
  logic                    err_d;
  logic                    load;
  logic                    accept;
  logic                    last_slot;
  logic [Q_W-1:0]          q_feat;

  tnn_quant #(
    .IN_W (IN_W),
    .Q_W  (Q_W)
  ) u_quant (
    .x (s_data),
    .q (q_feat)
  );

  assign last_slot = (idx_q == LAST_IDX);
  // Only the completing beat waits on the output register; all others flow.
  assign s_ready   = (state_q == DISCARD) | !last_slot | !m_valid_q | m_ready;
  assign accept    = s_valid & s_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    err_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          asm_d[idx_q] = q_feat;
          if (!last_slot) begin
            if (s_last) begin
              idx_d = '0;
              err_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            idx_d = '0;
            if (s_last) begin
              load = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = DISCARD;
            end
          end
        end
      end
      DISCARD: begin
        if (accept && s_last) begin
          idx_d   = '0;
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      asm_q       <= '0;
      m_valid_q   <= 1'b0;
      m_feat_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      frame_err_q <= err_d;
      // A completion in the same cycle as a drain reloads, keeping m_valid high.
      if (load) begin
        m_valid_q <= 1'b1;
        m_feat_q  <= asm_d;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_valid   = m_valid_q;
  assign m_feat    = m_feat_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Scoreboard bench for tnn_feature_packer: directed samples, framing errors, backpressure, reset.
module tb_tnn_feature_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [14:0] m_feat;
  logic        frame_err;

  tnn_feature_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_feat    (m_feat),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  logic [7:0]  smp   [5][5];
  logic [14:0] exp_w [5];
  logic [14:0] exp_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int err_pulses  = 0;
  int err_cycles  = 0;
  int stalls      = 0;
  int pops        = 0;
  logic frame_err_d = 1'b0;

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    logic [14:0] e;
    if (rst_n) begin
      if (frame_err) err_cycles++;
      if (frame_err && !frame_err_d) err_pulses++;
      frame_err_d <= frame_err;
      if (m_valid && m_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL out_word: got unexpected word %o, none required", m_feat);
        end else begin
          e = exp_q.pop_front();
          pops++;
          if (m_feat !== e) begin
            miscompares++;
            $display("FAIL out_word: got %o, required %o", m_feat, e);
          end
        end
      end
    end else begin
      frame_err_d <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    bit acc;
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    acc = 1'b0;
    n   = 0;
    while (!acc) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        stalls++;
        n++;
        if (n > 50) begin
          miscompares++;
          $display("FAIL send_timeout: got no s_ready in 50 cycles, required accept");
          acc = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_data  = 8'hff;
    s_last  = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sample(input int k);
    exp_q.push_back(exp_w[k]);
    for (int i = 0; i < 5; i++) send(smp[k][i], i == 4);
  endtask

  initial begin
    int s0;
    int p0;
    int c0;
    int w0;
    smp[0] = '{8'd0,   8'd16,  8'd47,  8'd128, 8'd255};
    smp[1] = '{8'd15,  8'd48,  8'd79,  8'd80,  8'd239};
    smp[2] = '{8'd255, 8'd240, 8'd112, 8'd111, 8'd32};
    smp[3] = '{8'd200, 8'd100, 8'd50,  8'd25,  8'd12};
    smp[4] = '{8'd31,  8'd32,  8'd63,  8'd64,  8'd95};
    exp_w[0] = 15'o74110;
    exp_w[1] = 15'o73220;
    exp_w[2] = 15'o13477;
    exp_w[3] = 15'o01236;
    exp_w[4] = 15'o32211;

    // Reset state
    #12;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_feat", {17'd0, m_feat}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single sample, one-cycle latency
    exp_q.push_back(exp_w[0]);
    for (int i = 0; i < 4; i++) send(smp[0][i], 1'b0);
    check("t1_no_early_valid", {31'd0, m_valid}, 32'd0);
    send(smp[0][4], 1'b1);
    check("t1_valid_latency", {31'd0, m_valid}, 32'd1);
    check("t1_word", {17'd0, m_feat}, {17'd0, exp_w[0]});

    // 2: back-to-back samples, no stalls
    s0 = stalls;
    w0 = pops;
    for (int k = 1; k < 5; k++) send_sample(k);
    idle(3);
    check("t2_no_stall", stalls, s0);
    check("t2_words_out", pops - w0, 5);

    // 3: backpressure on the completing beat only
    send_sample(0);
    m_ready = 1'b0;
    s0 = stalls;
    for (int i = 0; i < 4; i++) send(smp[1][i], 1'b0);
    check("t3_early_beats_flow", stalls, s0);
    exp_q.push_back(exp_w[1]);
    s_valid = 1'b1;
    s_data  = smp[1][4];
    s_last  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t3_s_ready_low", {31'd0, s_ready}, 32'd0);
      check("t3_hold_word", {17'd0, m_feat}, {17'd0, exp_w[0]});
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    send(smp[1][4], 1'b1);
    check("t3_valid_kept", {31'd0, m_valid}, 32'd1);
    check("t3_reload_word", {17'd0, m_feat}, {17'd0, exp_w[1]});
    idle(3);

    // 4: short sample
    p0 = err_pulses;
    c0 = err_cycles;
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b1);
    idle(3);
    check("t4_err_pulse", err_pulses - p0, 1);
    check("t4_err_width", err_cycles - c0, 1);
    check("t4_no_valid", {31'd0, m_valid}, 32'd0);
    check("t4_sb_empty", exp_q.size(), 0);
    send_sample(4);
    idle(2);

    // 5: long sample, swallowed to s_last
    p0 = err_pulses;
    for (int i = 1; i <= 4; i++) send(8'(i * 30), 1'b0);
    send(8'd150, 1'b0);
    check("t5_err_on_beat5", {31'd0, frame_err}, 32'd1);
    send(8'd180, 1'b0);
    send(8'd210, 1'b1);
    idle(3);
    check("t5_err_once", err_pulses - p0, 1);
    check("t5_no_valid", {31'd0, m_valid}, 32'd0);
    send_sample(2);
    idle(2);

    // 6: reset mid-sample and with held output
    send(smp[0][0], 1'b0);
    send(smp[0][1], 1'b0);
    rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    check("t6_rst_mid_valid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(smp[3][i], i == 4);
    check("t6_held_valid", {31'd0, m_valid}, 32'd1);
    check("t6_held_word", {17'd0, m_feat}, {17'd0, exp_w[3]});
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_kills_valid", {31'd0, m_valid}, 32'd0);
    check("t6_rst_clears_word", {17'd0, m_feat}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    send_sample(2);
    check("t6_fresh_word", {17'd0, m_feat}, {17'd0, exp_w[2]});
    idle(2);

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) idle(1);
    check("final_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
